// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared size codes, MMIO offsets and status bit indices for dmem_responder
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } sizeCode_e;

    localparam logic [3:0] OFF_CYCLE  = 4'h0;
    localparam logic [3:0] OFF_CMP    = 4'h4;
    localparam logic [3:0] OFF_STATUS = 4'h8;

    localparam int STAT_TIMER    = 0;
    localparam int STAT_MISALIGN = 1;

endpackage

// File: rtl/dmem_store_align.sv
// rtl/dmem_store_align.sv - maps a right-aligned store onto byte lanes and flags misalignment
module dmem_store_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addrLo,
    input  logic [31:0] writeData,
    output logic [3:0]  byteEn,
    output logic [31:0] laneData,
    output logic        misaligned
);

    always_comb begin
        byteEn     = 4'b0000;
        laneData   = writeData;
        misaligned = 1'b0;
        case (size)
            SZ_BYTE: begin
                byteEn   = 4'b0001 << addrLo;
                laneData = {4{writeData[7:0]}};
            end
            SZ_HALF: begin
                laneData = {2{writeData[15:0]}};
                if (addrLo[0]) misaligned = 1'b1;
                else           byteEn = addrLo[1] ? 4'b1100 : 4'b0011;
            end
            SZ_WORD: begin
                if (addrLo != 2'b00) misaligned = 1'b1;
                else                 byteEn = 4'b1111;
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - zero-wait data memory with MMIO cycle/compare/status window
// Define DMEM_MMIO_TIMER_EN to build the cycle counter, CMP register and timer_irq.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [1:0]  InstrM,
    output logic [31:0] ReadDataM,
    output logic        timer_irq,
    output logic        misaligned_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] wordIdx;
    logic [3:0]    mmioOff;
    logic          inWindow;
    logic [3:0]    byteEn;
    logic [31:0]   laneData;
    logic          misaligned;
    logic          regWrite;
    logic          faultSet;
    logic          timerHit;
    logic [1:0]    status;
    logic [1:0]    statusNext;

    assign wordIdx  = ALUResultM[AW+1:2];
    assign mmioOff  = {ALUResultM[3:2], 2'b00};
    assign inWindow = (ALUResultM[31:4] == MMIO_BASE[31:4]);

    dmem_store_align u_align (
        .size       (InstrM),
        .addrLo     (ALUResultM[1:0]),
        .writeData  (WriteDataM),
        .byteEn     (byteEn),
        .laneData   (laneData),
        .misaligned (misaligned)
    );

    // Any sub-word access into the window is a fault even when lane-aligned.
    assign faultSet = MemWriteM && (misaligned || (inWindow && InstrM != SZ_WORD));
    assign regWrite = MemWriteM && inWindow && InstrM == SZ_WORD && !misaligned;

    always_ff @(posedge clk) begin
        if (!reset && MemWriteM && !inWindow) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) mem[wordIdx][i*8 +: 8] <= laneData[i*8 +: 8];
            end
        end
    end

`ifdef DMEM_MMIO_TIMER_EN
    logic [31:0] cycle;
    logic [31:0] cmp;

    assign timerHit = (cmp != 32'd0) && (cycle == cmp);

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle <= 32'd0;
            cmp   <= 32'd0;
        end else begin
            cycle <= cycle + 32'd1;
            if (regWrite && mmioOff == OFF_CMP) cmp <= WriteDataM;
        end
    end

    assign timer_irq = status[STAT_TIMER];
`else
    assign timerHit  = 1'b0;
    assign timer_irq = 1'b0;
`endif

    // Sets are applied after the W1C mask so a coincident set wins.
    always_comb begin
        statusNext = status;
        if (regWrite && mmioOff == OFF_STATUS) statusNext = status & ~WriteDataM[1:0];
        if (timerHit) statusNext[STAT_TIMER]    = 1'b1;
        if (faultSet) statusNext[STAT_MISALIGN] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) status <= 2'b00;
        else       status <= statusNext;
    end

    assign misaligned_err = status[STAT_MISALIGN];

    always_comb begin
        ReadDataM = mem[wordIdx];
        if (inWindow) begin
            ReadDataM = 32'd0;
`ifdef DMEM_MMIO_TIMER_EN
            case (mmioOff)
                OFF_CYCLE:  ReadDataM = cycle;
                OFF_CMP:    ReadDataM = cmp;
                OFF_STATUS: ReadDataM = {30'd0, status};
                default:    ReadDataM = 32'd0;
            endcase
`endif
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed scoreboard bench for dmem_responder
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam logic [31:0] BASE = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemWriteM = 1'b0;
    logic [31:0] ALUResultM = 32'd0;
    logic [31:0] WriteDataM = 32'd0;
    logic [1:0]  InstrM = 2'b00;
    logic [31:0] ReadDataM;
    logic        timer_irq;
    logic        misaligned_err;

    logic [31:0] model [64];
    logic [31:0] sb [$];
    int          nAsserts = 0;
    int          nFail = 0;
    int          cyc = 0;

    always #5 clk = ~clk;

    dmem_responder dut (
        .clk            (clk),
        .reset          (reset),
        .MemWriteM      (MemWriteM),
        .ALUResultM     (ALUResultM),
        .WriteDataM     (WriteDataM),
        .InstrM         (InstrM),
        .ReadDataM      (ReadDataM),
        .timer_irq      (timer_irq),
        .misaligned_err (misaligned_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) cyc = 0;
        else       cyc++;
        #1;
    endtask

    task automatic modelStore(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        logic [5:0] idx;
        logic [1:0] lo;
        idx = a[7:2];
        lo  = a[1:0];
        if (a[31:4] == BASE[31:4]) return;
        case (sz)
            2'b00: model[idx][8*lo +: 8] = d[7:0];
            2'b01: if (!lo[0]) model[idx][16*lo[1] +: 16] = d[15:0];
            2'b10: if (lo == 2'b00) model[idx] = d;
            default: ;
        endcase
    endtask

    task automatic doStore(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        ALUResultM = a;
        WriteDataM = d;
        InstrM     = sz;
        MemWriteM  = 1'b1;
        if (!reset) modelStore(a, d, sz);
        tick();
        MemWriteM = 1'b0;
    endtask

    task automatic doRead(input string tag, input logic [31:0] a, input logic [31:0] exp);
        sb.push_back(exp);
        MemWriteM  = 1'b0;
        ALUResultM = a;
        #2;
        check(tag, ReadDataM, sb.pop_front());
    endtask

    task automatic ramRead(input string tag, input logic [31:0] a);
        logic [5:0] idx;
        idx = a[7:2];
        doRead(tag, a, model[idx]);
    endtask

    initial begin
        logic [31:0] tgt;
        tick();
        tick();
        check("reset_irq", {31'd0, timer_irq}, 32'd0);
        check("reset_err", {31'd0, misaligned_err}, 32'd0);
        reset = 1'b0;

        // word then byte
        doStore(32'h10, 32'h1122_3344, SZ_WORD);
        doRead("word_10", 32'h10, 32'h1122_3344);
        doStore(32'h12, 32'h0000_00AA, SZ_BYTE);
        doRead("byte_12", 32'h10, 32'h11AA_3344);
        doRead("addr_lo_ignored", 32'h13, 32'h11AA_3344);

        // every byte lane
        doStore(32'h40, 32'h0000_0000, SZ_WORD);
        for (int i = 0; i < 4; i++) begin
            doStore(32'h40 + i, 32'h5A00 + i, SZ_BYTE);
            ramRead("byte_lane", 32'h40);
        end
        check("lanes_const", model[16], 32'h0302_0100);

        // half stores
        doStore(32'h20, 32'h5566_7788, SZ_WORD);
        doStore(32'h22, 32'h1234_BEEF, SZ_HALF);
        doRead("half_22", 32'h20, 32'hBEEF_7788);
        doStore(32'h20, 32'hFFFF_CAFE, SZ_HALF);
        doRead("half_20", 32'h20, 32'hBEEF_CAFE);

        // aliasing modulo 256 bytes
        doStore(32'h0000_0114, 32'hA5A5_0001, SZ_WORD);
        doRead("alias_14", 32'h14, 32'hA5A5_0001);

        // misaligned half, W1C clear
        doStore(32'h21, 32'h0000_1111, SZ_HALF);
        doRead("mis_half_ram", 32'h20, 32'hBEEF_CAFE);
        check("mis_half_err", {31'd0, misaligned_err}, 32'd1);
        doStore(BASE + 32'h8, 32'h2, SZ_WORD);
        check("w1c_err", {31'd0, misaligned_err}, 32'd0);

        // misaligned word and reserved size
        doStore(32'h12, 32'hDEAD_DEAD, SZ_WORD);
        doRead("mis_word_ram", 32'h10, 32'h11AA_3344);
        check("mis_word_err", {31'd0, misaligned_err}, 32'd1);
        doStore(BASE + 32'h8, 32'h2, SZ_WORD);
        doStore(32'h10, 32'hDEAD_DEAD, SZ_RSVD);
        doRead("rsvd_ram", 32'h10, 32'h11AA_3344);
        check("rsvd_err", {31'd0, misaligned_err}, 32'd1);
        doStore(BASE + 32'h8, 32'h2, SZ_WORD);

        // sub-word store into window
        doStore(BASE + 32'h4, 32'h77, SZ_BYTE);
        check("win_byte_err", {31'd0, misaligned_err}, 32'd1);
`ifdef DMEM_MMIO_TIMER_EN
        doRead("win_byte_cmp", BASE + 32'h4, 32'd0);
`endif

        // window does not alias into RAM
        doStore(32'h04, 32'h0BAD_F00D, SZ_WORD);
        doStore(BASE + 32'h4, 32'h0000_0033, SZ_WORD);
        doRead("win_no_alias", 32'h04, 32'h0BAD_F00D);
        doRead("win_reg_c", BASE + 32'hC, 32'd0);
`ifndef DMEM_MMIO_TIMER_EN
        doRead("win_cmp_zero", BASE + 32'h4, 32'd0);
        doRead("win_cycle_zero", BASE, 32'd0);
        check("irq_tied", {31'd0, timer_irq}, 32'd0);
`endif

        // reset with a store in flight
        doStore(32'h30, 32'h3030_3030, SZ_WORD);
        reset = 1'b1;
        doStore(32'h30, 32'hFFFF_FFFF, SZ_WORD);
        reset = 1'b0;
        doRead("rst_store_drop", 32'h30, 32'h3030_3030);
        check("rst_err", {31'd0, misaligned_err}, 32'd0);
        doRead("rst_status", BASE + 32'h8, 32'd0);
        doRead("rst_cmp", BASE + 32'h4, 32'd0);
        doRead("rst_cycle", BASE, 32'd0);

`ifdef DMEM_MMIO_TIMER_EN
        // timer fires on the edge where CYCLE == CMP
        doStore(BASE + 32'h4, 32'd20, SZ_WORD);
        doRead("cmp_rd", BASE + 32'h4, 32'd20);
        while (cyc < 20) tick();
        doRead("cycle_20", BASE, 32'd20);
        check("irq_before", {31'd0, timer_irq}, 32'd0);
        tick();
        check("irq_rise", {31'd0, timer_irq}, 32'd1);
        doStore(BASE, 32'h1234_5678, SZ_WORD);
        tick();
        tick();
        check("irq_sticky", {31'd0, timer_irq}, 32'd1);
        doRead("cycle_ro", BASE, cyc);
        doRead("status_rd", BASE + 32'h8, 32'd1);
        doStore(BASE + 32'h8, 32'h1, SZ_WORD);
        check("irq_w1c", {31'd0, timer_irq}, 32'd0);

        // W1C on the same edge as a set: set wins
        tgt = cyc + 3;
        doStore(BASE + 32'h4, tgt, SZ_WORD);
        while (cyc != tgt) tick();
        doStore(BASE + 32'h8, 32'h1, SZ_WORD);
        check("set_wins", {31'd0, timer_irq}, 32'd1);
        doRead("set_wins_status", BASE + 32'h8, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the M-stage interface of the pipelined RISC-V core.
- Accepts address, store data, write strobe and a size code from the core, and returns a read word with zero wait states.
- Performs sized, byte-lane stores into an internal word array.
- Maps a small register window containing a cycle counter, a timer compare register and a sticky status/IRQ register.

Parameters:
- DEPTH_WORDS, 64, number of 32-bit RAM words; must be a power of 2.
- MMIO_BASE, 32'hFFFF_0000, base of the MMIO window; the window is 16 bytes, and addr[31:4] must equal MMIO_BASE[31:4].

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- MemWriteM  in  1  store strobe for this cycle
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- InstrM  in  2  access size: 00 byte, 01 half, 10 word, 11 reserved
- ReadDataM  out  32  word-aligned read data, combinational from address
- timer_irq  out  1  level interrupt; mirrors status bit0
- misaligned_err  out  1  sticky store-fault flag; mirrors status bit1

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - cycle counter, compare and status clear to 0.
  - timer_irq = 0, misaligned_err = 0.
  - RAM contents are not cleared.
  - A store presented in a reset cycle is dropped.
- Reads:
  - Combinational, zero latency.
  - ReadDataM = mem[ALUResultM[log2(DEPTH_WORDS)+1:2]] for RAM addresses; addr[1:0] is ignored.
  - The core extracts and sign-extends sub-word data itself.
- RAM addressing: any address outside the MMIO window hits RAM; upper bits are ignored, so addresses alias modulo DEPTH_WORDS*4.
- Stores take effect on the rising edge with MemWriteM=1; a read of the same address in the next cycle returns the new data.
  - Byte: lane = addr[1:0]; WriteDataM[7:0] goes to that lane; other lanes unchanged.
  - Half: requires addr[0]=0; lanes {addr[1]*2+1, addr[1]*2} take WriteDataM[15:0].
  - Word: requires addr[1:0]=0; all lanes written.
  - Misaligned half/word, or size 11: no write; misaligned_err sets on that edge.
- MMIO map (offsets from MMIO_BASE; word access only):
  - 0x0 CYCLE: read-only; increments every non-reset cycle; wraps 32'hFFFF_FFFF -> 0; writes ignored.
  - 0x4 CMP: read/write.
  - 0x8 STATUS: bit0 timer, bit1 misaligned; write-1-to-clear.
  - 0xC: reads 0; writes ignored.
  - A non-word store into the window sets misaligned_err and changes no register.
- Timer:
  - On an edge where CMP != 0 and CYCLE == CMP (pre-increment value), status bit0 sets.
  - CMP = 0 disables the timer.
- Simultaneous events:
  - If a W1C clear and a set of the same status bit occur on one edge, the set wins.
  - A write to CMP takes effect from the next compare.

Optional Feature:
- Macro: DMEM_MMIO_TIMER_EN.
- Defined: MMIO window, counter, CMP and timer_irq behave as specified.
- Undefined:
  - No counter or CMP registers are built.
  - Window reads return 0 and window stores are ignored.
  - timer_irq is tied to 0.
  - Window addresses still do not alias into RAM.
  - misaligned_err logic is unchanged.

Decomposition:
- Shared package `dmem_pkg`:
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD.
  - MMIO offsets OFF_CYCLE/OFF_CMP/OFF_STATUS.
  - STATUS bit indices.
- One sub-module, `dmem_store_align`: combinational; takes size, addr[1:0] and WriteDataM; produces a 4-bit byte-enable, lane-shifted data and a misaligned flag.

Test Plan:
- Word then byte: write 32'h1122_3344 @0x10, then byte 8'hAA @0x12 -> read @0x10 = 32'h11AA_3344.
- Half store @0x22: store 16'hBEEF @0x22 -> read @0x20 has [31:16]=16'hBEEF, lower half unchanged.
- Misaligned half: half store @0x21 -> RAM unchanged, misaligned_err=1 next cycle; W1C 32'h2 to STATUS -> clears to 0.
- Timer: write CMP=20 right after reset -> timer_irq rises on the edge where CYCLE==20; it stays high until W1C 32'h1.
- Simultaneous set and clear: W1C issued in the same cycle CYCLE==CMP -> timer_irq remains 1.
- Reset mid-store: assert reset with MemWriteM=1 @0x30 -> word @0x30 keeps its old value; all MMIO registers = 0.
